// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem.
// Holds the arbiter FSM state encoding and the channel-count limit.
package lc3b_types;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_CH = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Rotated priority search: the first requesting channel at or after base wins.
// The arbiter ties base to zero to get fixed lowest-index priority.
module arb_rr_pick #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   base,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    logic [CH_W:0]   sum_s;
    logic [CH_W-1:0] cand_s;

    // Walk channels base, base+1, ... modulo NUM_CH and keep the first hit.
    always_comb begin
        winner = {CH_W{1'b0}};
        valid  = 1'b0;
        sum_s  = {(CH_W+1){1'b0}};
        cand_s = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s = {1'b0, base} + (CH_W+1)'(i);
            if (sum_s >= (CH_W+1)'(NUM_CH)) begin
                sum_s = sum_s - (CH_W+1)'(NUM_CH);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[CH_W-1:0];
            if (!valid && req[cand_s]) begin
                valid  = 1'b1;
                winner = cand_s;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_CH request ports onto one registered physical-memory port.
// Define ARB_RR_EN for round-robin fairness; otherwise lowest index wins.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [CH_W-1:0]          grant_id,
    output logic                     busy
);

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [CH_W-1:0]   base_s;
    logic [CH_W-1:0]   win_s;
    logic              any_s;
    logic [NUM_CH-1:0] req_s;
    logic [ADDR_W-1:0] addr_a [NUM_CH];
    logic [DATA_W-1:0] wdata_a [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_a[g]  = ch_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = ch_wdata[g*DATA_W +: DATA_W];
    end

    assign req_s = ch_read | ch_write;

`ifdef ARB_RR_EN
    logic [CH_W-1:0] ptr_q, ptr_d;
    assign base_s = ptr_q;

    // Round-robin pointer: search restarts just past the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {CH_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Next pointer on a fresh grant, wrapping at NUM_CH.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && any_s) begin
            if (win_s == CH_W'(NUM_CH-1)) begin
                ptr_d = {CH_W{1'b0}};
            end else begin
                ptr_d = win_s + CH_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end
`else
    assign base_s = {CH_W{1'b0}};
`endif

    arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req    (req_s),
        .base   (base_s),
        .winner (win_s),
        .valid  (any_s)
    );

    // FSM and operand latch: capture the winner in IDLE, hold until mem_resp.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_s) begin
                    state_d = ARB_BUSY;
                    grant_d = win_s;
                    addr_d  = addr_a[win_s];
                    wdata_d = wdata_a[win_s];
                    wr_d    = ch_write[win_s];
                    rd_d    = ~ch_write[win_s];
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and latched-access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= {CH_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Completion pulse routed to the owner; stray responses in IDLE are dropped.
    always_comb begin
        ch_resp = {NUM_CH{1'b0}};
        if (state_q == ARB_BUSY && mem_resp) begin
            ch_resp[grant_q] = 1'b1;
        end else begin
            ch_resp = {NUM_CH{1'b0}};
        end
    end

    assign ch_rdata    = mem_rdata;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ARB_BUSY);

endmodule
